// File: rtl/vga_timing_pkg.sv
// Shared timing constants (640x480 @ 60 Hz) and the run/idle state encoding
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-around position counter with synchronous clear and enable; exposes the
// next value so the top can decode registered outputs with zero skew.
module vga_axis_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v position counters plus registered sync,
// display-enable and start pulses, running only while the PLL is locked.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  state_t state_q, state_d;

  logic             cnt_clr;
  logic             h_tc;
  logic             v_tc;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic frame_start_q, frame_start_d;
  logic line_start_q, line_start_d;
  logic run_nxt;

  // Counters advance only while already running and still locked; every
  // other edge (idle, start-up, lock loss) loads position (0,0).
  assign cnt_clr = !((state_q == ST_RUN) && pll_locked);

  vga_axis_counter #(.WIDTH(CNT_W), .MAX(H_TOTAL)) u_h_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (1'b1),
    .count     (h_cnt),
    .count_nxt (h_nxt),
    .tc        (h_tc)
  );

  vga_axis_counter #(.WIDTH(CNT_W), .MAX(V_TOTAL)) u_v_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cnt_clr),
    .en        (h_tc),
    .count     (v_cnt),
    .count_nxt (v_nxt),
    .tc        (v_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pll_locked)  state_d = ST_RUN;
      ST_RUN:  if (!pll_locked) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the counters' next values so they land in the
  // same cycle as the position they describe.
  always_comb begin
    run_nxt       = (state_d == ST_RUN);
    de_d          = run_nxt && (h_nxt < H_ACT_END) && (v_nxt < V_ACT_END);
    hsync_d       = !(run_nxt && (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END));
    vsync_d       = !(run_nxt && (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END));
    line_start_d  = run_nxt && (h_nxt == '0);
    frame_start_d = run_nxt && (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

  logic unused_v_tc;
  assign unused_v_tc = v_tc;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porches and sync in lines.
REQ-007 SHALL have port clk  input  1  25 MHz pixel clock from the PLL outclk_0; sole clock.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port pll_locked  input  1  PLL locked indication; timing runs only while high.
REQ-010 SHALL have port h_cnt  output  10  current horizontal position, 0..H_TOTAL-1.
REQ-011 SHALL have port v_cnt  output  10  current vertical position, 0..V_TOTAL-1.
REQ-012 SHALL have port hsync  output  1  horizontal sync, active-low.
REQ-013 SHALL have port vsync  output  1  vertical sync, active-low.
REQ-014 SHALL have port de  output  1  display enable, high in the visible area.
REQ-015 SHALL have port frame_start  output  1  one-clock pulse at position (0,0).
REQ-016 SHALL have port line_start  output  1  one-clock pulse at every h_cnt==0.

Function
REQ-017 SHALL define H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL likewise (525).
REQ-018 SHALL implement a two-state FSM: IDLE (held) and RUN (counting).
REQ-019 SHALL, in IDLE, hold h_cnt=0, v_cnt=0, hsync=1, vsync=1, de=0, frame_start=0, line_start=0.
REQ-020 SHALL go IDLE->RUN on the edge where pll_locked is sampled 1, loading position (0,0) with de=1, frame_start=1, line_start=1 on that same edge.
REQ-021 SHALL, in RUN, increment h_cnt by 1 per clock; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-022 SHALL wrap v_cnt from V_TOTAL-1 to 0 on the edge where h_cnt wraps; the frame period is exactly H_TOTAL*V_TOTAL clocks (420000).
REQ-023 SHALL drive all outputs from flops, with hsync/vsync/de/pulses aligned to h_cnt/v_cnt of the same cycle (zero skew).
REQ-024 SHALL assert de iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-025 SHALL drive hsync=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-026 SHALL drive vsync=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for whole lines.
REQ-027 SHALL go RUN->IDLE on the edge where pll_locked is sampled 0, mid-line or mid-frame, applying the IDLE values of REQ-019 on that edge.
REQ-028 SHALL restart from (0,0) per REQ-020 when lock returns; no position is retained across a lock loss.

Reset
REQ-029 SHALL, on any edge with rst_n=0, enter IDLE with REQ-019 values, overriding pll_locked.
REQ-030 SHALL evaluate the REQ-020 transition on the first edge with rst_n=1.

Structure
REQ-031 SHALL take the default timing constants and the FSM state enum from the shared package vga_timing_pkg.
REQ-032 SHALL instantiate sub-module vga_axis_counter (wrap counter with enable, terminal-count output) twice: horizontal and vertical.

Verification
REQ-033 Reset with pll_locked=1, release rst_n -> first edge gives h_cnt=0, v_cnt=0, de=1, frame_start=1; the next frame_start comes exactly 420000 clocks later.
REQ-034 Run one line -> hsync low for exactly 96 clocks starting at h_cnt=656; de high for h_cnt 0..639 only.
REQ-035 Run one frame -> vsync low for exactly 2*800 clocks starting at (0,490); de low for all v_cnt>=480.
REQ-036 Wrap at (799,524) -> next cycle (0,0), frame_start=1, line_start=1; wrap at (799,100) -> (0,101), line_start=1, frame_start=0.
REQ-037 Drop pll_locked at (300,200) -> next edge is IDLE values; reassert it -> restart at (0,0) with frame_start=1.
REQ-038 Assert rst_n=0 at (700,491) during hsync and vsync -> next edge hsync=1, vsync=1, de=0, counters 0.
